regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  in  1  single clock, all state changes on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 we  in  1  write enable, driven from the execute stage's wreg_o after pipeline registers.
REQ-004 waddr  in  5  write destination register number, driven from wd_o.
REQ-005 wdata  in  32  write data, driven from wdata_o.
REQ-006 re1  in  1  read port 1 enable.
REQ-007 raddr1  in  5  read port 1 register number.
REQ-008 rdata1  out  32  read port 1 data, feeding the execute stage's reg1_i.
REQ-009 re2  in  1  read port 2 enable.
REQ-010 raddr2  in  5  read port 2 register number.
REQ-011 rdata2  out  32  read port 2 data, feeding the execute stage's reg2_i.

Function
REQ-012 The block SHALL hold 32 general registers of 32 bits, indices 0-31.
REQ-013 A write SHALL occur on the rising clk edge when rst=1, we=1 and waddr!=0; the register at waddr then takes wdata.
REQ-014 A write with waddr=0 SHALL be discarded; register 0 SHALL read 0 at all times.
REQ-015 A write with we=0 SHALL leave every register unchanged.
REQ-016 Reads SHALL be combinational: rdataN reflects raddrN and reNs in the same cycle, with zero added latency.
REQ-017 rdataN SHALL be 0 when reN=0, when raddrN=0, or when rst=0, in that priority after reset.
REQ-018 Otherwise, rdataN SHALL be the stored contents of register raddrN, subject to REQ-024.
REQ-019 The two read ports SHALL be independent; both SHALL return identical data when given the same address.
REQ-020 A write and two reads to three different registers in one cycle SHALL all complete without interference.
REQ-021 The block SHALL contain no state beyond the 32x32 array; register 0 need not be physically stored.

Reset
REQ-022 While rst=0, all registers 1-31 SHALL be forced to 0 asynchronously, independent of clk.
REQ-023 While rst=0, rdata1 and rdata2 SHALL be 0, and writes SHALL be ignored. This includes a write presented on the same edge at which rst rises; the first accepted write is on the first rising edge after rst is sampled 1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding. The feature is compiled in when the macro is defined and compiled out when it is not.
REQ-025 With REGFILE_BYPASS_EN defined: when reN=1, raddrN=waddr, we=1 and waddr!=0 in the same cycle, rdataN SHALL equal wdata combinationally in that cycle.
REQ-026 Without REGFILE_BYPASS_EN: in the same case, rdataN SHALL return the pre-write stored value, and the new value SHALL be visible from the next cycle.
REQ-027 Without REGFILE_BYPASS_EN, the pipeline SHALL resolve the hazard by stalling; this block SHALL NOT signal the hazard.
REQ-028 Neither configuration SHALL change the interface, the reset behaviour or the register-0 behaviour.

Verification
REQ-029 Reset: assert rst=0 mid-cycle after writing r5=0x12345678 -> rdata1 (re1=1, raddr1=5) = 0 immediately without a clock edge; after release, r5 still reads 0.
REQ-030 Write/read: we=1, waddr=7, wdata=0xDEADBEEF at edge N; at cycle N+1, re1=1, raddr1=7, re2=1, raddr2=7 -> rdata1 = rdata2 = 0xDEADBEEF.
REQ-031 Register zero: we=1, waddr=0, wdata=0xFFFFFFFF -> next cycle raddr1=0, re1=1 gives rdata1=0; no other register changed.
REQ-032 Read disable: r3=0x00000055, re2=0, raddr2=3 -> rdata2=0; set re2=1 -> rdata2=0x00000055 in the same cycle.
REQ-033 Same-cycle hazard: r9=0x1, then we=1, waddr=9, wdata=0x2 with re1=1, raddr1=9 in the same cycle -> rdata1=0x2 with REGFILE_BYPASS_EN and 0x1 without; in both builds rdata1=0x2 the next cycle.
REQ-034 Full sweep: write r1-r31 with value 0xA5000000+index on consecutive cycles -> read back all 31 values on both ports with no aliasing.

Source files
------------

// File: rtl/regfile_if.sv
// regfile_if: register-file access bus grouping the write port and both read ports.
//   master: drives we/waddr/wdata, re1/raddr1, re2/raddr2; receives rdata1/rdata2
//   slave : the register file, which returns rdata1/rdata2
interface regfile_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    modport master (output we, waddr, wdata, re1, raddr1, re2, raddr2, input rdata1, rdata2);
    modport slave  (input we, waddr, wdata, re1, raddr1, re2, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/regfile.sv
// regfile: 32x32 general register file, one write port, two combinational read ports.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears r1-r31 and zeroes both read ports
//   bus : regfile_if.slave (we/waddr/wdata write, re1/raddr1/rdata1 and re2/raddr2/rdata2 reads)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports; otherwise a same-cycle read returns the pre-write value.
module regfile (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);
    // r0 is hardwired to zero, so only r1-r31 are stored
    logic [31:0] regs_q [1:31];
    logic        byp1;
    logic        byp2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
        end else if (bus.we && bus.waddr != 5'd0) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // waddr != 0 is implied: a read of r0 is zeroed before the bypass is considered
    assign byp1 = bus.we && bus.waddr == bus.raddr1;
    assign byp2 = bus.we && bus.waddr == bus.raddr2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign bus.rdata1 = (!rst || !bus.re1 || bus.raddr1 == 5'd0) ? '0 :
                        byp1 ? bus.wdata : regs_q[bus.raddr1];
    assign bus.rdata2 = (!rst || !bus.re2 || bus.raddr2 == 5'd0) ? '0 :
                        byp2 ? bus.wdata : regs_q[bus.raddr2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed table-driven bench for regfile plus reset and sweep sequences.
module tb_regfile;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    regfile_if bus ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t v [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd1;
        bus.re2 = 1'b1; bus.raddr2 = 5'd31;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rd1", bus.rdata1, 32'h0);
        chk("reset_rd2", bus.rdata2, 32'h0);
        rst = 1'b1;
        #1;
        chk("post_reset_r1", bus.rdata1, 32'h0);

        v[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7,  1'b0, 5'd7,  32'h0, 32'h0};
        v[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        v[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd7,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0};
        v[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd7,  32'h0, 32'hDEADBEEF};
        v[4]  = '{1'b1, 5'd3,  32'h00000055, 1'b1, 5'd7,  1'b0, 5'd3,  32'hDEADBEEF, 32'h0};
        v[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  32'h55, 32'h0};
        v[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  32'h55, 32'h55};
        v[7]  = '{1'b1, 5'd9,  32'h1,        1'b1, 5'd3,  1'b1, 5'd7,  32'h55, 32'hDEADBEEF};
        v[8]  = '{1'b1, 5'd9,  32'h2,        1'b1, 5'd9,  1'b1, 5'd9,  BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
        v[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd3,  32'h2, 32'h55};
        v[10] = '{1'b0, 5'd3,  32'hFFFFFFFF, 1'b1, 5'd3,  1'b1, 5'd7,  32'h55, 32'hDEADBEEF};
        v[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd9,  32'h55, 32'h2};
        v[12] = '{1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd7,  1'b1, 5'd3,  32'hDEADBEEF, 32'h55};
        v[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 1'b1, 5'd0,  32'hCAFEF00D, 32'h0};

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bus.we = v[i].we; bus.waddr = v[i].waddr; bus.wdata = v[i].wdata;
            bus.re1 = v[i].re1; bus.raddr1 = v[i].ra1;
            bus.re2 = v[i].re2; bus.raddr2 = v[i].ra2;
            #3;
            chk($sformatf("row%0d_rd1", i), bus.rdata1, v[i].e1);
            chk($sformatf("row%0d_rd2", i), bus.rdata2, v[i].e2);
        end

        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            idle();
            bus.we = 1'b1; bus.waddr = 5'(i); bus.wdata = 32'hA5000000 + 32'(i);
        end
        @(posedge clk);
        #1;
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.re1 = 1'b1; bus.raddr1 = 5'(i);
            bus.re2 = 1'b1; bus.raddr2 = 5'(32 - i);
            #2;
            chk($sformatf("sweep_rd1_r%0d", i), bus.rdata1, 32'hA5000000 + 32'(i));
            chk($sformatf("sweep_rd2_r%0d", 32 - i), bus.rdata2, 32'hA5000000 + 32'(32 - i));
        end

        @(posedge clk);
        #1;
        idle();
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h12345678;
        @(posedge clk);
        #1;
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        #1;
        chk("r5_before_reset", bus.rdata1, 32'h12345678);
        #1 rst = 1'b0;
        #1;
        chk("r5_async_reset", bus.rdata1, 32'h0);
        bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h00000077;
        bus.re2 = 1'b1; bus.raddr2 = 5'd6;
        #1;
        chk("rd2_in_reset_with_write", bus.rdata2, 32'h0);
        @(posedge clk);
        #1;
        chk("r5_reset_after_edge", bus.rdata1, 32'h0);
        bus.we = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("r5_after_release", bus.rdata1, 32'h0);
        chk("r6_write_in_reset_ignored", bus.rdata2, 32'h0);
        @(posedge clk);
        #1;
        bus.raddr1 = 5'd31;
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h00000ABC;
        bus.raddr2 = 5'd5;
        #2;
        chk("r31_cleared_by_reset", bus.rdata1, 32'h0);
        chk("r5_same_cycle_after_reset", bus.rdata2, BYP ? 32'h00000ABC : 32'h0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        #2;
        chk("r5_write_after_reset", bus.rdata2, 32'h00000ABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
